fir_to_fft_deadlock_reporter: RTL and testbench

Consumes the per-channel AXIS block status produced by the fir_to_fft deadlock monitor and decides whether the stall is a real deadlock. It counts consecutive blocked cycles, trips once a programmable threshold is reached, and then does three things: emits one timestamped report word over a valid/ready handshake, holds a sticky deadlock flag, and keeps a saturating trip count. It sits directly downstream of the monitor and upstream of the debug/status register bank.

---
 rtl/fir_to_fft_deadlock_pkg.sv | 26 ++
 rtl/fir_to_fft_sat_counter.sv | 27 ++
 rtl/fir_to_fft_deadlock_reporter.sv | 157 +++++++++++++++
 tb/tb_fir_to_fft_deadlock_reporter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_to_fft_deadlock_pkg.sv
// ---------------------------------------------------------------------------
// fir_to_fft_deadlock_pkg
//
// Shared definitions for the fir_to_fft deadlock reporter:
//   state_t        - reporter FSM states (IDLE, COUNT, REPORT, TRIPPED)
//   INFO_FIELD_W   - width of one channel's status field inside block_info
//   mask_from_info - reduces one channel's status field to its blocked bit;
//                    the top applies it to every field to build cur_mask
// ---------------------------------------------------------------------------
package fir_to_fft_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_REPORT  = 2'd2,
        ST_TRIPPED = 2'd3
    } state_t;

    localparam int INFO_FIELD_W = 2;

    // A channel is blocked when any bit of its status field is set.
    function automatic logic mask_from_info(input logic [INFO_FIELD_W-1:0] field);
        return |field;
    endfunction

endpackage

// File: rtl/fir_to_fft_sat_counter.sv
// ---------------------------------------------------------------------------
// fir_to_fft_sat_counter
//
// Up-counter that sticks at its all-ones value.
//   clock  in  clock
//   inc    in  count one event this cycle
//   clr    in  synchronous clear to zero (wins over inc)
//   count  out current count
// ---------------------------------------------------------------------------
module fir_to_fft_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fir_to_fft_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// fir_to_fft_deadlock_reporter
//
// Watches the deadlock monitor's per-channel block status, counts consecutive
// blocked cycles and trips once THRESH is reached. A trip raises a sticky
// deadlock flag, emits one {mask, timestamp} report word and bumps a
// saturating trip counter. clear re-arms the detector after a trip.
//
// Ports:
//   clock         in   clock
//   reset         in   synchronous, active-high reset
//   block         in   some channel blocked this cycle
//   block_info    in   2 bits per channel; channel i blocked when field != 0
//   clear         in   re-arm pulse (aborts counting, releases TRIPPED)
//   report_ready  in   sink accepts the report word
//   report_valid  out  report word available (held until accepted)
//   report_data   out  {mask[N_CHAN-1:0], timestamp[TS_W-1:0]}
//   deadlock      out  sticky deadlock flag
//   block_mask    out  accumulated blocked-channel mask of the trip
//   event_count   out  saturating number of trips (cleared by reset only)
//
// Handshake: a report word transfers on the clock edge where report_valid
// and report_ready are both high; report_valid never drops before that edge
// and report_data is stable while report_valid is high.
// ---------------------------------------------------------------------------
module fir_to_fft_deadlock_reporter
    import fir_to_fft_deadlock_pkg::*;
#(
    parameter int N_CHAN = 2,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32,
    parameter int EVT_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     block,
    input  logic [2*N_CHAN-1:0]      block_info,
    input  logic                     clear,
    input  logic                     report_ready,
    output logic                     report_valid,
    output logic [N_CHAN+TS_W-1:0]   report_data,
    output logic                     deadlock,
    output logic [N_CHAN-1:0]        block_mask,
    output logic [EVT_W-1:0]         event_count
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [N_CHAN-1:0]  acc_q, acc_d;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    ts_cap_q, ts_cap_d;
    logic [N_CHAN-1:0]  cur_mask;
    logic               enter_report;

    // Blocked-channel mask for this cycle, one bit per status field.
    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            cur_mask[i] = mask_from_info(block_info[INFO_FIELD_W*i +: INFO_FIELD_W]);
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ts_cap_d = ts_cap_q;
        case (state_q)
            ST_IDLE: begin
                if (block) begin
                    cnt_d = CNT_W'(1);
                    acc_d = cur_mask;
                    // A threshold of one trips on the first blocked cycle.
                    if (THRESH == 1) begin
                        ts_cap_d = ts_q;
                        state_d  = ST_REPORT;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                // clear wins over block; either one discards the episode.
                if (clear || !block) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    acc_d = acc_q | cur_mask;
                    if (cnt_inc == THRESH_C) begin
                        ts_cap_d = ts_q;
                        state_d  = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (report_ready) begin
                    state_d = ST_TRIPPED;
                end
            end
            ST_TRIPPED: begin
                if (clear) begin
                    cnt_d    = '0;
                    acc_d    = '0;
                    ts_cap_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                cnt_d    = '0;
                acc_d    = '0;
                ts_cap_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    assign enter_report = (state_d == ST_REPORT) && (state_q != ST_REPORT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ts_cap_q <= '0;
            ts_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ts_cap_q <= ts_cap_d;
            ts_q     <= ts_q + TS_W'(1);
        end
    end

    fir_to_fft_sat_counter #(
        .W (EVT_W)
    ) u_event_counter (
        .clock (clock),
        .inc   (enter_report),
        .clr   (reset),
        .count (event_count)
    );

    // All outputs decode registered state only.
    assign report_valid = (state_q == ST_REPORT);
    assign report_data  = report_valid ? {acc_q, ts_cap_q} : '0;
    assign deadlock     = (state_q == ST_REPORT) || (state_q == ST_TRIPPED);
    assign block_mask   = deadlock ? acc_q : '0;

endmodule

// File: tb/tb_fir_to_fft_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// tb_fir_to_fft_deadlock_reporter
//
// Two reporter instances:
//   dut_a  N_CHAN=2, THRESH=4, TS_W=32, EVT_W=2  (latency, mask, hold,
//          clear priority, saturation, reset during REPORT)
//   dut_b  N_CHAN=2, THRESH=1, TS_W=4,  EVT_W=8  (single-cycle trips,
//          timestamp wrap)
// Expected report words are pushed when a trip is predicted and popped by
// per-instance monitors whenever a report word is transferred.
// ---------------------------------------------------------------------------
module tb_fir_to_fft_deadlock_reporter;

  localparam int THRESH_A = 4;
  localparam int TS_W_A   = 32;
  localparam int EVT_W_A  = 2;
  localparam int TS_W_B   = 4;
  localparam int EVT_W_B  = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a, reset_b;

  // ---------------- DUT A ----------------
  logic                  block_a, clear_a, report_ready_a;
  logic [3:0]            block_info_a;
  logic                  report_valid_a, deadlock_a;
  logic [2+TS_W_A-1:0]   report_data_a;
  logic [1:0]            block_mask_a;
  logic [EVT_W_A-1:0]    event_count_a;

  fir_to_fft_deadlock_reporter #(
    .N_CHAN (2), .THRESH (THRESH_A), .CNT_W (16), .TS_W (TS_W_A), .EVT_W (EVT_W_A)
  ) dut_a (
    .clock        (clock),
    .reset        (reset_a),
    .block        (block_a),
    .block_info   (block_info_a),
    .clear        (clear_a),
    .report_ready (report_ready_a),
    .report_valid (report_valid_a),
    .report_data  (report_data_a),
    .deadlock     (deadlock_a),
    .block_mask   (block_mask_a),
    .event_count  (event_count_a)
  );

  // ---------------- DUT B ----------------
  logic                  block_b, clear_b, report_ready_b;
  logic [3:0]            block_info_b;
  logic                  report_valid_b, deadlock_b;
  logic [2+TS_W_B-1:0]   report_data_b;
  logic [1:0]            block_mask_b;
  logic [EVT_W_B-1:0]    event_count_b;

  fir_to_fft_deadlock_reporter #(
    .N_CHAN (2), .THRESH (1), .CNT_W (16), .TS_W (TS_W_B), .EVT_W (EVT_W_B)
  ) dut_b (
    .clock        (clock),
    .reset        (reset_b),
    .block        (block_b),
    .block_info   (block_info_b),
    .clear        (clear_b),
    .report_ready (report_ready_b),
    .report_valid (report_valid_b),
    .report_data  (report_data_b),
    .deadlock     (deadlock_b),
    .block_mask   (block_mask_b),
    .event_count  (event_count_b)
  );

  // ---------------- reference model state ----------------
  // Free-running timestamps as the spec defines them: 0 in reset, +1 per cycle.
  logic [TS_W_A-1:0] ts_a;
  logic [TS_W_B-1:0] ts_b;
  always @(posedge clock) ts_a <= reset_a ? '0 : ts_a + 1'b1;
  always @(posedge clock) ts_b <= reset_b ? '0 : ts_b + 1'b1;

  logic [2+TS_W_A-1:0] exp_q_a[$];
  logic [2+TS_W_B-1:0] exp_q_b[$];

  int   n_checks = 0;
  int   n_pass   = 0;

  bit   armed_a = 1'b1;   // detector waiting for a new episode
  int   run_a   = 0;      // consecutive blocked cycles in current episode
  logic [1:0] racc_a = '0;
  int   trips_a = 0;

  function automatic logic [1:0] ref_mask(input logic [3:0] info);
    logic [1:0] m;
    for (int i = 0; i < 2; i++) m[i] = (((info >> (2 * i)) & 4'h3) != 4'h0);
    return m;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One cycle of stimulus on dut_a, with the episode model updated alongside.
  task automatic cyc_a(input logic blk, input logic [3:0] info, input logic clr);
    block_a      = blk;
    block_info_a = info;
    clear_a      = clr;
    if (armed_a) begin
      if (clr || !blk) begin
        run_a  = 0;
        racc_a = '0;
      end else begin
        run_a++;
        racc_a |= ref_mask(info);
        if (run_a == THRESH_A) begin
          exp_q_a.push_back({racc_a, ts_a});
          armed_a = 1'b0;
          trips_a++;
        end
      end
    end
    tick();
    block_a = 1'b0;
    clear_a = 1'b0;
  endtask

  // Accept the pending report after wait_cycles of back-pressure, then re-arm.
  task automatic accept_and_clear_a(input int wait_cycles);
    report_ready_a = 1'b0;
    repeat (wait_cycles) tick();
    report_ready_a = 1'b1;
    tick();
    report_ready_a = 1'b0;
    check("a_valid_drop_after_xfer", report_valid_a, 0);
    check("a_deadlock_sticky", deadlock_a, 1);
    cyc_a(1'b0, 4'h0, 1'b1);
    check("a_deadlock_after_clear", deadlock_a, 0);
    check("a_mask_after_clear", block_mask_a, 0);
    run_a   = 0;
    racc_a  = '0;
    armed_a = 1'b1;
  endtask

  task automatic check_tripped_a();
    check("a_valid_on_trip", report_valid_a, 1);
    check("a_deadlock_on_trip", deadlock_a, 1);
    check("a_mask_on_trip", block_mask_a, racc_a);
    check("a_event_count", event_count_a, sat(trips_a, 3));
  endtask

  // ---------------- monitors ----------------
  logic                prev_v_a = 1'b0, prev_r_a = 1'b0;
  logic [2+TS_W_A-1:0] prev_d_a = '0;

  always @(negedge clock) begin
    if (reset_a) begin
      prev_v_a = 1'b0;
    end else begin
      if (prev_v_a && !prev_r_a) begin
        check("a_valid_held", report_valid_a, 1);
        check("a_data_stable", report_data_a, prev_d_a);
      end
      if (report_valid_a && report_ready_a) begin
        if (exp_q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_report_unexpected: got %0h expected none", report_data_a);
        end else begin
          check("a_report_data", report_data_a, exp_q_a.pop_front());
        end
      end
      prev_v_a = report_valid_a;
      prev_r_a = report_ready_a;
      prev_d_a = report_data_a;
    end
  end

  always @(negedge clock) begin
    if (!reset_b && report_valid_b && report_ready_b) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_report_unexpected: got %0h expected none", report_data_b);
      end else begin
        check("b_report_data", report_data_b, exp_q_b.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] info;
    logic [1:0] m;
    int         pre;

    reset_a = 1'b1; reset_b = 1'b1;
    block_a = 1'b0; clear_a = 1'b0; report_ready_a = 1'b0; block_info_a = '0;
    block_b = 1'b0; clear_b = 1'b0; report_ready_b = 1'b0; block_info_b = '0;
    repeat (3) tick();
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // Reset state
    check("a_rst_valid", report_valid_a, 0);
    check("a_rst_data", report_data_a, 0);
    check("a_rst_deadlock", deadlock_a, 0);
    check("a_rst_mask", block_mask_a, 0);
    check("a_rst_events", event_count_a, 0);
    check("b_rst_valid", report_valid_b, 0);
    check("b_rst_events", event_count_b, 0);

    // Basic trip: four blocked cycles on channel 0, report in cycle 4.
    for (int k = 0; k < THRESH_A; k++) begin
      cyc_a(1'b1, 4'b0010, 1'b0);
      if (k == THRESH_A - 2) check("a_no_valid_before_thresh", report_valid_a, 0);
    end
    check_tripped_a();
    accept_and_clear_a(0);

    // Broken window: 3 high, 1 low, 3 high -> no trip.
    repeat (3) cyc_a(1'b1, 4'b0011, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b0);
    repeat (3) cyc_a(1'b1, 4'b1100, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b0);
    check("a_broken_window_deadlock", deadlock_a, 0);
    check("a_broken_window_events", event_count_a, 1);

    // Mask accumulation across channels, with ten cycles of back-pressure.
    cyc_a(1'b1, 4'b0001, 1'b0);
    cyc_a(1'b1, 4'b0001, 1'b0);
    cyc_a(1'b1, 4'b0100, 1'b0);
    cyc_a(1'b1, 4'b0100, 1'b0);
    check("a_mask_both_channels", block_mask_a, 2'b11);
    check_tripped_a();
    accept_and_clear_a(10);

    // clear beats block while counting, episode restarts afterwards.
    cyc_a(1'b1, 4'b0010, 1'b0);
    cyc_a(1'b1, 4'b0010, 1'b0);
    cyc_a(1'b1, 4'b1000, 1'b1);
    repeat (3) cyc_a(1'b1, 4'b1000, 1'b0);
    check("a_clear_priority_no_trip", deadlock_a, 0);
    cyc_a(1'b1, 4'b1000, 1'b0);
    check_tripped_a();
    accept_and_clear_a($urandom_range(0, 3));

    // Randomized episodes: short aborted runs then a full trip; counter saturates.
    for (int it = 0; it < 6; it++) begin
      pre = $urandom_range(0, THRESH_A - 1);
      for (int k = 0; k < pre; k++) cyc_a(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      cyc_a(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      for (int k = 0; k < THRESH_A; k++) cyc_a(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      check_tripped_a();
      accept_and_clear_a($urandom_range(0, 5));
    end
    check("a_events_saturated", event_count_a, 3);

    // Reset while a report is pending: the report is dropped.
    for (int k = 0; k < THRESH_A; k++) cyc_a(1'b1, 4'b0110, 1'b0);
    check("a_valid_before_reset", report_valid_a, 1);
    reset_a = 1'b1;
    void'(exp_q_a.pop_back());
    tick();
    reset_a = 1'b0;
    check("a_reset_valid", report_valid_a, 0);
    check("a_reset_data", report_data_a, 0);
    check("a_reset_deadlock", deadlock_a, 0);
    check("a_reset_mask", block_mask_a, 0);
    check("a_reset_events", event_count_a, 0);
    trips_a = 0; run_a = 0; racc_a = '0; armed_a = 1'b1;
    tick();
    for (int k = 0; k < THRESH_A; k++) cyc_a(1'b1, 4'($urandom_range(1, 15)), 1'b0);
    check_tripped_a();
    accept_and_clear_a(2);

    // THRESH=1 instance: line a pulse up with the last timestamp before wrap.
    for (int k = 0; k < 20 && ts_b != 4'hF; k++) tick();
    check("b_ts_aligned", ts_b, 4'hF);
    for (int p = 0; p < 40; p++) begin
      info = (p == 0) ? 4'b1001 : 4'($urandom_range(0, 15));
      m    = ref_mask(info);
      exp_q_b.push_back({m, ts_b});
      block_b      = 1'b1;
      block_info_b = info;
      tick();
      block_b = 1'b0;
      check("b_valid_next_cycle", report_valid_b, 1);
      check("b_mask", block_mask_b, m);
      check("b_events", event_count_b, p + 1);
      report_ready_b = 1'b1;
      tick();
      report_ready_b = 1'b0;
      check("b_valid_drop", report_valid_b, 0);
      clear_b = 1'b1;
      tick();
      clear_b = 1'b0;
      check("b_deadlock_cleared", deadlock_b, 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    check("a_queue_drained", exp_q_a.size(), 0);
    check("b_queue_drained", exp_q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
